// File: rtl/player_hit_manager.sv
// player_hit_manager: turns the collision level into game state.
// Tracks lives, runs a frame-counted invincibility window after each hit,
// drives the sprite blink enable and raises game_over at zero lives.
// Optional feature macro: EXTRA_LIFE_EN adds the extra_life input.
module player_hit_manager #(
    parameter int LIVES_INIT    = 3,
    parameter int LIFE_W        = 2,
    parameter int INVULN_FRAMES = 120,
    parameter int INV_W         = 7,
    parameter int BLINK_SHIFT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_tick,
    input  logic              collision,
    input  logic              restart,
`ifdef EXTRA_LIFE_EN
    input  logic              extra_life,
`endif
    output logic [LIFE_W-1:0] lives,
    output logic              invincible,
    output logic              player_visible,
    output logic              hit_pulse,
    output logic              game_over
);

    typedef enum logic [1:0] {
        ST_ALIVE  = 2'd0,
        ST_INVULN = 2'd1,
        ST_OVER   = 2'd2
    } state_t;

    localparam logic [LIFE_W-1:0] LIVES_RELOAD = LIFE_W'(LIVES_INIT);
    localparam logic [LIFE_W-1:0] LIVES_MAX    = {LIFE_W{1'b1}};
    localparam logic [LIFE_W-1:0] LIVES_ONE    = LIFE_W'(1);
    localparam logic [INV_W-1:0]  INV_LOAD     = INV_W'(INVULN_FRAMES);
    localparam logic [INV_W-1:0]  INV_ONE      = INV_W'(1);

    state_t             state_q, state_d;
    logic [LIFE_W-1:0]  lives_q, lives_d;
    logic [INV_W-1:0]   inv_cnt_q, inv_cnt_d;
    logic               invincible_q, invincible_d;
    logic               player_visible_q, player_visible_d;
    logic               hit_pulse_q, hit_pulse_d;
    logic               game_over_q, game_over_d;
    logic               extra_life_w;

`ifdef EXTRA_LIFE_EN
    assign extra_life_w = extra_life;
`else
    assign extra_life_w = 1'b0;
`endif

    // State register: FSM state, lives and invincibility counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_ALIVE;
            lives_q   <= LIVES_RELOAD;
            inv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    // Next-state logic: hits, invincibility countdown, restart and extra lives
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        inv_cnt_d = inv_cnt_q;
        if (restart) begin
            // restart wins over everything, including a same-cycle collision
            state_d   = ST_ALIVE;
            lives_d   = LIVES_RELOAD;
            inv_cnt_d = '0;
        end else begin
            case (state_q)
                ST_ALIVE: begin
                    if (collision) begin
                        if (extra_life_w) begin
                            // extra life cancels the decrement; never a game over
                            state_d   = ST_INVULN;
                            inv_cnt_d = INV_LOAD;
                        end else if (lives_q <= LIVES_ONE) begin
                            lives_d = '0;
                            state_d = ST_OVER;
                        end else begin
                            lives_d   = lives_q - LIVES_ONE;
                            state_d   = ST_INVULN;
                            inv_cnt_d = INV_LOAD;
                        end
                    end else if (extra_life_w && lives_q != LIVES_MAX) begin
                        lives_d = lives_q + LIVES_ONE;
                    end
                end
                ST_INVULN: begin
                    if (extra_life_w && lives_q != LIVES_MAX) begin
                        lives_d = lives_q + LIVES_ONE;
                    end
                    if (frame_tick) begin
                        if (inv_cnt_q <= INV_ONE) begin
                            inv_cnt_d = '0;
                            state_d   = ST_ALIVE;
                        end else begin
                            inv_cnt_d = inv_cnt_q - INV_ONE;
                        end
                    end
                end
                ST_OVER: begin
                    lives_d   = '0;
                    inv_cnt_d = '0;
                end
                default: begin
                    state_d = ST_ALIVE;
                end
            endcase
        end
    end

    // Output logic: registered outputs reflect the state being entered
    always_comb begin
        hit_pulse_d    = !restart && (state_q == ST_ALIVE) && collision;
        invincible_d   = (state_d == ST_INVULN);
        game_over_d    = (state_d == ST_OVER);
        if (state_d == ST_INVULN) begin
            player_visible_d = ~inv_cnt_d[BLINK_SHIFT];
        end else begin
            player_visible_d = (state_d != ST_OVER);
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            invincible_q     <= 1'b0;
            player_visible_q <= 1'b1;
            hit_pulse_q      <= 1'b0;
            game_over_q      <= 1'b0;
        end else begin
            invincible_q     <= invincible_d;
            player_visible_q <= player_visible_d;
            hit_pulse_q      <= hit_pulse_d;
            game_over_q      <= game_over_d;
        end
    end

    assign lives          = lives_q;
    assign invincible     = invincible_q;
    assign player_visible = player_visible_q;
    assign hit_pulse      = hit_pulse_q;
    assign game_over      = game_over_q;

endmodule

// File: tb/tb_player_hit_manager.sv
// Testbench for player_hit_manager: directed scenarios plus random stimulus,
// all checked against a frame-timer/lives reference model.
module tb_player_hit_manager;

    localparam int LIVES_INIT = 3;
    localparam int LIFE_W     = 2;
    localparam int FRAMES     = 4;
    localparam int LIVES_MAX  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              frame_tick = 1'b0;
    logic              collision = 1'b0;
    logic              restart = 1'b0;
    logic              extra_life = 1'b0;
    logic [LIFE_W-1:0] lives;
    logic              invincible;
    logic              player_visible;
    logic              hit_pulse;
    logic              game_over;

    int n_vec = 0;
    int n_err = 0;

    // reference model: remaining lives, remaining invulnerable frames, over flag
    int m_lives;
    int m_timer;
    bit m_over;
    bit m_hit;

    player_hit_manager #(
        .LIVES_INIT(LIVES_INIT),
        .LIFE_W(LIFE_W),
        .INVULN_FRAMES(FRAMES),
        .INV_W(3),
        .BLINK_SHIFT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_tick(frame_tick),
        .collision(collision),
        .restart(restart),
`ifdef EXTRA_LIFE_EN
        .extra_life(extra_life),
`endif
        .lives(lives),
        .invincible(invincible),
        .player_visible(player_visible),
        .hit_pulse(hit_pulse),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lives = LIVES_INIT;
        m_timer = 0;
        m_over  = 1'b0;
        m_hit   = 1'b0;
    endtask

    // one clock edge of game rules
    task automatic model_step(input bit c, input bit t, input bit r, input bit e);
        m_hit = 1'b0;
        if (r) begin
            m_lives = LIVES_INIT;
            m_timer = 0;
            m_over  = 1'b0;
        end else if (m_over) begin
            m_lives = 0;
        end else if (m_timer > 0) begin
            if (e) m_lives = (m_lives + 1 > LIVES_MAX) ? LIVES_MAX : m_lives + 1;
            if (t) m_timer = m_timer - 1;
        end else if (c) begin
            m_hit = 1'b1;
            if (e) begin
                m_timer = FRAMES;
            end else if (m_lives <= 1) begin
                m_lives = 0;
                m_over  = 1'b1;
            end else begin
                m_lives = m_lives - 1;
                m_timer = FRAMES;
            end
        end else if (e) begin
            m_lives = (m_lives + 1 > LIVES_MAX) ? LIVES_MAX : m_lives + 1;
        end
    endtask

    task automatic check_all(input string tag);
        int vis;
        if (m_over) vis = 0;
        else if (m_timer > 0) vis = ((m_timer / 2) % 2 == 0) ? 1 : 0;
        else vis = 1;
        check({tag, ".lives"}, 32'(lives), 32'(m_lives));
        check({tag, ".invincible"}, 32'(invincible), 32'(m_timer > 0));
        check({tag, ".visible"}, 32'(player_visible), 32'(vis));
        check({tag, ".hit_pulse"}, 32'(hit_pulse), 32'(m_hit));
        check({tag, ".game_over"}, 32'(game_over), 32'(m_over));
    endtask

    // apply one cycle of inputs (called #1 after a posedge), then check
    task automatic step(input string tag, input bit c, input bit t, input bit r, input bit e);
        collision  = c;
        frame_tick = t;
        restart    = r;
`ifdef EXTRA_LIFE_EN
        extra_life = e;
`else
        extra_life = 1'b0;
`endif
        @(posedge clk);
`ifdef EXTRA_LIFE_EN
        model_step(c, t, r, e);
`else
        model_step(c, t, r, 1'b0);
`endif
        #1;
        check_all(tag);
    endtask

    task automatic run_invuln_out(input string tag, input bit c);
        for (int i = 0; i < FRAMES; i++) step(tag, c, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int hits;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // 1: reset state
        check("rst.lives", 32'(lives), 32'(3));
        check("rst.invincible", 32'(invincible), 32'(0));
        check("rst.visible", 32'(player_visible), 32'(1));
        check("rst.game_over", 32'(game_over), 32'(0));
        check("rst.hit_pulse", 32'(hit_pulse), 32'(0));
        rst = 1'b1;

        // 2: single hit, with a frame tick on the hit cycle, then 4 ticks
        step("t2.hit", 1'b1, 1'b1, 1'b0, 1'b0);
        check("t2.lives2", 32'(lives), 32'(2));
        check("t2.inv1", 32'(invincible), 32'(1));
        run_invuln_out("t2.tick", 1'b0);
        check("t2.inv0", 32'(invincible), 32'(0));

        // 3: collision held 20 clks through INVULN without ticks
        step("t3.restart", 1'b0, 1'b0, 1'b1, 1'b0);
        hits = 0;
        for (int i = 0; i < 20; i++) begin
            step("t3.hold", 1'b1, 1'b0, 1'b0, 1'b0);
            hits += int'(hit_pulse);
        end
        check("t3.hits", 32'(hits), 32'(1));
        check("t3.lives", 32'(lives), 32'(2));
        // still held across INVULN->ALIVE: a fresh hit
        run_invuln_out("t3.exit", 1'b1);
        step("t3.rehit", 1'b1, 1'b0, 1'b0, 1'b0);

        // 4: three hits to game over, then restart
        step("t4.restart", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int h = 0; h < 3; h++) begin
            step("t4.hit", 1'b1, 1'b0, 1'b0, 1'b0);
            if (h < 2) run_invuln_out("t4.tick", 1'b0);
        end
        check("t4.over", 32'(game_over), 32'(1));
        check("t4.vis0", 32'(player_visible), 32'(0));
        for (int i = 0; i < 5; i++) step("t4.ignored", 1'b1, 1'b1, 1'b0, 1'b0);
        step("t4.restart2", 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4.lives3", 32'(lives), 32'(3));

        // 5: restart beats collision
        step("t5.both", 1'b1, 1'b0, 1'b1, 1'b0);
        check("t5.nohit", 32'(hit_pulse), 32'(0));

`ifdef EXTRA_LIFE_EN
        // 6: saturation and extra life cancelling a hit
        step("t6.sat", 1'b0, 1'b0, 1'b0, 1'b1);
        check("t6.lives3", 32'(lives), 32'(3));
        for (int h = 0; h < 2; h++) begin
            step("t6.hit", 1'b1, 1'b0, 1'b0, 1'b0);
            run_invuln_out("t6.tick", 1'b0);
        end
        step("t6.cancel", 1'b1, 1'b0, 1'b0, 1'b1);
        check("t6.lives1", 32'(lives), 32'(1));
        check("t6.inv", 32'(invincible), 32'(1));
`endif

        // asynchronous reset mid-run takes effect without a clock edge
        step("ar.pre", 1'b1, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        check("ar.lives", 32'(lives), 32'(3));
        check("ar.invincible", 32'(invincible), 32'(0));
        check("ar.hit_pulse", 32'(hit_pulse), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;

        // random stimulus
        for (int i = 0; i < 1500; i++) begin
            step("rnd",
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 1) == 1),
                 ($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
